// File: rtl/zxbus_port_ctrl.sv
// zxbus_port_ctrl: ZX bus I/O access sequencer for ports #81AB, #82AB, #83AB.
// Synchronises the raw Z80 I/O strobes and decodes the port address. It then
// drives the port block's write interface and the read-data output enable.
// Build option: define ZXPORTS_RDOE_ASYNC_EN for a combinational zx_d_oe
// decoded straight from the raw bus (zero-latency read drive).
//
// Bus handshake: an access starts only from IDLE, when the synchronised IORQ
// and RD/WR are both active and the address decodes (M1 low = INTA, ignored).
// A write always runs the full setup/strobe/hold sequence. It then parks in
// WAIT_END until IORQ and WR are both released, so one bus cycle produces
// exactly one strobe. A read holds zx_d_oe until RD or IORQ is released.
module zxbus_port_ctrl #(
    parameter int STB_LEN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] zx_a,
    input  logic [7:0]  zx_d,
    input  logic        zx_iorq_n,
    input  logic        zx_rd_n,
    input  logic        zx_wr_n,
    input  logic        zx_m1_n,
    output logic [1:0]  port_addr,
    output logic [7:0]  port_wrdata,
    output logic        port_wrena,
    output logic        port_wrstb_n,
    output logic        zx_d_oe,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_SETUP = 3'd1,
        WR_STB   = 3'd2,
        WR_HOLD  = 3'd3,
        RD_ACT   = 3'd4,
        WAIT_END = 3'd5
    } state_t;

    // Strobe counter load value: counts down to zero over STB_LEN cycles.
    localparam logic [3:0] STB_LAST = 4'(STB_LEN - 1);

    // Address decode shared by the synchronised and the raw-bus paths.
    function automatic logic addr_match(input logic [15:0] a);
        return (a[7:0] == 8'hAB) && (a[15:10] == 6'b100000) && (a[9:8] != 2'b00);
    endfunction

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [1:0]  addr_n;
    logic [7:0]  data_n;
    logic        wrena_n;
    logic        wrstb_n_n;
    logic        oe_q, oe_n;

    // Synchroniser stages, bit order {m1, wr, rd, iorq}, active-high.
    logic [3:0]  sync1, sync2;
    logic        iorq_s, rd_s, wr_s, m1_s;
    logic        hit;

    // Two-flop synchroniser for the raw active-low strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
        end else begin
            sync1 <= ~{zx_m1_n, zx_wr_n, zx_rd_n, zx_iorq_n};
            sync2 <= sync1;
        end
    end

    assign iorq_s = sync2[0];
    assign rd_s   = sync2[1];
    assign wr_s   = sync2[2];
    assign m1_s   = sync2[3];

    // INTA cycles (M1 together with IORQ) never match.
    assign hit = addr_match(zx_a) && iorq_s && !m1_s;

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            port_addr    <= 2'b00;
            port_wrdata  <= 8'h00;
            port_wrena   <= 1'b0;
            port_wrstb_n <= 1'b1;
            oe_q         <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            port_addr    <= addr_n;
            port_wrdata  <= data_n;
            port_wrena   <= wrena_n;
            port_wrstb_n <= wrstb_n_n;
            oe_q         <= oe_n;
        end
    end

    // Next-state and next-output logic; every output holds unless changed.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        addr_n    = port_addr;
        data_n    = port_wrdata;
        wrena_n   = port_wrena;
        wrstb_n_n = port_wrstb_n;
        oe_n      = oe_q;
        case (state)
            IDLE: begin
                if (hit && wr_s) begin
                    state_n = WR_SETUP;
                    addr_n  = zx_a[9:8];
                    data_n  = zx_d;
                    wrena_n = 1'b1;
                end else if (hit && rd_s) begin
                    state_n = RD_ACT;
                    addr_n  = zx_a[9:8];
                    oe_n    = 1'b1;
                end
            end
            WR_SETUP: begin
                state_n   = WR_STB;
                wrstb_n_n = 1'b0;
                cnt_n     = STB_LAST;
            end
            WR_STB: begin
                // IORQ release is ignored here so the pulse is never truncated.
                if (cnt == 4'd0) begin
                    state_n   = WR_HOLD;
                    wrstb_n_n = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            WR_HOLD: begin
                state_n = WAIT_END;
                wrena_n = 1'b0;
            end
            RD_ACT: begin
                if (!rd_s || !iorq_s) begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                end
            end
            WAIT_END: begin
                if (!iorq_s && !wr_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

`ifdef ZXPORTS_RDOE_ASYNC_EN
    // Raw-bus read enable: no synchroniser latency, the FSM only reports busy.
    assign zx_d_oe = ~zx_iorq_n & ~zx_rd_n & zx_m1_n & addr_match(zx_a);
`else
    // Registered read enable, owned by the RD_ACT state.
    assign zx_d_oe = oe_q;
`endif

endmodule

// File: tb/tb_zxbus_port_ctrl.sv
// tb_zxbus_port_ctrl: bench for zxbus_port_ctrl, two instances (STB_LEN 2 and 4)
// sharing one ZX bus. Outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_zxbus_port_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] zx_a = 16'h0000;
    logic [7:0]  zx_d = 8'h00;
    logic        zx_iorq_n = 1'b1;
    logic        zx_rd_n = 1'b1;
    logic        zx_wr_n = 1'b1;
    logic        zx_m1_n = 1'b1;

    logic [1:0] addr_o [2];
    logic [7:0] data_o [2];
    logic [1:0] ena_o, stb_o, oe_o, busy_o;

    zxbus_port_ctrl #(.STB_LEN(2)) u_dut2 (
        .clk(clk), .rst(rst), .zx_a(zx_a), .zx_d(zx_d),
        .zx_iorq_n(zx_iorq_n), .zx_rd_n(zx_rd_n), .zx_wr_n(zx_wr_n), .zx_m1_n(zx_m1_n),
        .port_addr(addr_o[0]), .port_wrdata(data_o[0]), .port_wrena(ena_o[0]),
        .port_wrstb_n(stb_o[0]), .zx_d_oe(oe_o[0]), .busy(busy_o[0])
    );

    zxbus_port_ctrl #(.STB_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .zx_a(zx_a), .zx_d(zx_d),
        .zx_iorq_n(zx_iorq_n), .zx_rd_n(zx_rd_n), .zx_wr_n(zx_wr_n), .zx_m1_n(zx_m1_n),
        .port_addr(addr_o[1]), .port_wrdata(data_o[1]), .port_wrena(ena_o[1]),
        .port_wrstb_n(stb_o[1]), .zx_d_oe(oe_o[1]), .busy(busy_o[1])
    );

`ifdef ZXPORTS_RDOE_ASYNC_EN
    localparam int OE_MIN = 1;
    localparam int OE_MAX = 1;
`else
    localparam int OE_MIN = 2;
    localparam int OE_MAX = 4;
`endif

    int n_checks = 0;
    int n_pass = 0;

    // ---------------- reference model / scoreboard ----------------
    logic [9:0] exp_q[$];      // expected {port_addr, port_wrdata} per strobe
    logic [9:0] rise_q0[$];    // observed at each rising strobe, STB_LEN 2
    logic [9:0] rise_q1[$];    // observed at each rising strobe, STB_LEN 4

    // A port is selected when the low byte is AB and the high byte is 81..83,
    // and the cycle is not an interrupt acknowledge.
    function automatic bit model_hit(input logic [15:0] a, input bit m1);
        int hi_byte;
        int lo_byte;
        hi_byte = int'(a) / 256;
        lo_byte = int'(a) % 256;
        return (lo_byte == 'hAB) && (hi_byte >= 'h81) && (hi_byte <= 'h83) && !m1;
    endfunction

    function automatic logic [1:0] model_port(input logic [15:0] a);
        return 2'((int'(a) / 256) - 'h80);
    endfunction

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 9))
            0, 1:    return 16'h81AB;
            2, 3:    return 16'h82AB;
            4, 5:    return 16'h83AB;
            6:       return 16'h80AB;
            7:       return 16'h83AA;
            8:       return 16'h87AB;
            default: return 16'($urandom);
        endcase
    endfunction

    // ---------------- observation state ----------------
    int cyc = 0;
    int drive_cyc = 0;
    int release_cyc = 0;
    int n_fall [2];
    int fall_cyc [2];
    int cur_low [2];
    int low_len [2];
    int n_bad [2];
    int n_oe_rise [2];
    int oe_rise_cyc [2];
    int oe_fall_cyc [2];
    logic [1:0] prev_stb, prev_ena, prev_oe;

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            n_fall[i] = 0; fall_cyc[i] = -1; cur_low[i] = 0; low_len[i] = 0;
            n_bad[i] = 0; n_oe_rise[i] = 0; oe_rise_cyc[i] = -1; oe_fall_cyc[i] = -1;
        end
        rise_q0.delete();
        rise_q1.delete();
        prev_stb = stb_o;
        prev_ena = ena_o;
        prev_oe  = oe_o;
    endtask

    // One clock cycle: sample on the falling edge and record strobe/oe events.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (prev_stb[i] && !stb_o[i]) begin
                n_fall[i]++;
                fall_cyc[i] = cyc;
                cur_low[i] = 0;
                if (!prev_ena[i] || !ena_o[i]) n_bad[i]++;
            end
            if (!stb_o[i]) cur_low[i]++;
            if (!prev_stb[i] && stb_o[i]) begin
                low_len[i] = cur_low[i];
                if (!ena_o[i]) n_bad[i]++;
                if (i == 0) rise_q0.push_back({addr_o[0], data_o[0]});
                else        rise_q1.push_back({addr_o[1], data_o[1]});
            end
            if (oe_o[i] && !prev_oe[i]) begin
                n_oe_rise[i]++;
                oe_rise_cyc[i] = cyc;
            end
            if (!oe_o[i] && prev_oe[i]) oe_fall_cyc[i] = cyc;
        end
        prev_stb = stb_o;
        prev_ena = ena_o;
        prev_oe  = oe_o;
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        zx_iorq_n = 1'b1;
        zx_rd_n   = 1'b1;
        zx_wr_n   = 1'b1;
        zx_m1_n   = 1'b1;
    endtask

    task automatic bus_start(input bit is_wr, input logic [15:0] a, input logic [7:0] d, input bit m1);
        zx_a = a;
        zx_d = d;
        zx_m1_n = ~m1;
        zx_iorq_n = 1'b0;
        if (is_wr) zx_wr_n = 1'b0;
        else       zx_rd_n = 1'b0;
        drive_cyc = cyc;
    endtask

    // Full bus cycle: hold the strobes, release, then wait (bounded) for IDLE.
    task automatic access(input bit is_wr, input logic [15:0] a, input logic [7:0] d,
                          input bit m1, input int hold);
        int w;
        bus_start(is_wr, a, d, m1);
        repeat (hold) tick();
        bus_idle();
        release_cyc = cyc;
        zx_a = 16'($urandom);
        zx_d = 8'($urandom);
        w = 0;
        while (busy_o != 2'b00 && w < 30) begin
            tick();
            w++;
        end
        n_checks++;
        if (busy_o !== 2'b00 || ena_o !== 2'b00 || stb_o !== 2'b11)
            $display("FAIL idle_after_access: busy=%b wrena=%b wrstb_n=%b, required 00/00/11",
                     busy_o, ena_o, stb_o);
        else n_pass++;
        repeat (2) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (addr_o[i] !== 2'b00) $display("FAIL reset_addr[%0d]: got %b, required 00", i, addr_o[i]);
            else n_pass++;
            n_checks++;
            if (data_o[i] !== 8'h00) $display("FAIL reset_wrdata[%0d]: got %h, required 00", i, data_o[i]);
            else n_pass++;
            n_checks++;
            if (ena_o[i] !== 1'b0) $display("FAIL reset_wrena[%0d]: got %b, required 0", i, ena_o[i]);
            else n_pass++;
            n_checks++;
            if (stb_o[i] !== 1'b1) $display("FAIL reset_wrstb_n[%0d]: got %b, required 1", i, stb_o[i]);
            else n_pass++;
            n_checks++;
            if (oe_o[i] !== 1'b0) $display("FAIL reset_d_oe[%0d]: got %b, required 0", i, oe_o[i]);
            else n_pass++;
            n_checks++;
            if (busy_o[i] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b, required 0", i, busy_o[i]);
            else n_pass++;
        end
        rst = 1'b0;
        clear_stats();
        repeat (4) tick();
        n_checks++;
        if (busy_o !== 2'b00 || stb_o !== 2'b11)
            $display("FAIL post_reset_idle: busy=%b wrstb_n=%b, required 00/11", busy_o, stb_o);
        else n_pass++;
    endtask

    task automatic test_write();
        logic [9:0] obs;
        clear_stats();
        access(1'b1, 16'h83AB, 8'h3C, 1'b0, 40);
        n_checks++;
        if (n_fall[0] !== 1) $display("FAIL write_pulse_count: got %0d, required 1", n_fall[0]);
        else n_pass++;
        n_checks++;
        if (low_len[0] !== 2) $display("FAIL write_pulse_len: got %0d, required 2", low_len[0]);
        else n_pass++;
        n_checks++;
        if (fall_cyc[0] - drive_cyc < 3 || fall_cyc[0] - drive_cyc > 4)
            $display("FAIL write_latency: got %0d cycles, required 3..4", fall_cyc[0] - drive_cyc);
        else n_pass++;
        n_checks++;
        if (n_bad[0] !== 0) $display("FAIL write_wrena_bracket: got %0d violations, required 0", n_bad[0]);
        else n_pass++;
        obs = (rise_q0.size() > 0) ? rise_q0.pop_front() : 10'bx;
        n_checks++;
        if (obs !== {2'b11, 8'h3C}) $display("FAIL write_addr_data: got %h, required %h", obs, {2'b11, 8'h3C});
        else n_pass++;
        n_checks++;
        if (addr_o[0] !== 2'b11 || data_o[0] !== 8'h3C)
            $display("FAIL write_hold_after: got %b/%h, required 11/3c", addr_o[0], data_o[0]);
        else n_pass++;
        n_checks++;
        if (n_oe_rise[0] !== 0) $display("FAIL write_no_oe: got %0d, required 0", n_oe_rise[0]);
        else n_pass++;
    endtask

    task automatic test_read();
        clear_stats();
        access(1'b0, 16'h82AB, 8'h00, 1'b0, 20);
        n_checks++;
        if (n_oe_rise[0] !== 1) $display("FAIL read_oe_count: got %0d, required 1", n_oe_rise[0]);
        else n_pass++;
        n_checks++;
        if (oe_rise_cyc[0] - drive_cyc < OE_MIN || oe_rise_cyc[0] - drive_cyc > OE_MAX)
            $display("FAIL read_oe_rise: got %0d, required %0d..%0d", oe_rise_cyc[0] - drive_cyc, OE_MIN, OE_MAX);
        else n_pass++;
        n_checks++;
        if (oe_fall_cyc[0] - release_cyc < OE_MIN || oe_fall_cyc[0] - release_cyc > OE_MAX)
            $display("FAIL read_oe_fall: got %0d, required %0d..%0d", oe_fall_cyc[0] - release_cyc, OE_MIN, OE_MAX);
        else n_pass++;
        n_checks++;
        if (addr_o[0] !== 2'b10) $display("FAIL read_addr: got %b, required 10", addr_o[0]);
        else n_pass++;
        n_checks++;
        if (n_fall !== '{0, 0}) $display("FAIL read_no_strobe: got %0d/%0d, required 0/0", n_fall[0], n_fall[1]);
        else n_pass++;
    endtask

    task automatic test_no_match();
        logic [15:0] tbl_a [4];
        bit          tbl_m1 [4];
        tbl_a  = '{16'h80AB, 16'h83AA, 16'h87AB, 16'h83AB};
        tbl_m1 = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 2; w++) begin
                clear_stats();
                access(w[0], tbl_a[k], 8'($urandom), tbl_m1[k], 15);
                n_checks++;
                if (n_fall[0] !== 0 || n_fall[1] !== 0 || n_oe_rise[0] !== 0 || n_oe_rise[1] !== 0)
                    $display("FAIL no_match a=%h m1=%0d wr=%0d: strobes %0d/%0d oe %0d/%0d, required all 0",
                             tbl_a[k], tbl_m1[k], w, n_fall[0], n_fall[1], n_oe_rise[0], n_oe_rise[1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_short_iorq();
        int w;
        clear_stats();
        bus_start(1'b1, 16'h81AB, 8'hA5, 1'b0);
        w = 0;
        while (ena_o[1] !== 1'b1 && w < 10) begin
            tick();
            w++;
        end
        n_checks++;
        if (ena_o[1] !== 1'b1) $display("FAIL short_iorq_start: wrena=%b, required 1", ena_o[1]);
        else n_pass++;
        tick();
        bus_idle();
        w = 0;
        while (busy_o != 2'b00 && w < 30) begin
            tick();
            w++;
        end
        tick();
        n_checks++;
        if (n_fall[1] !== 1 || low_len[1] !== 4)
            $display("FAIL short_iorq_stb4: pulses %0d len %0d, required 1 len 4", n_fall[1], low_len[1]);
        else n_pass++;
        n_checks++;
        if (n_fall[0] !== 1 || low_len[0] !== 2)
            $display("FAIL short_iorq_stb2: pulses %0d len %0d, required 1 len 2", n_fall[0], low_len[0]);
        else n_pass++;
        n_checks++;
        if (busy_o !== 2'b00 || n_bad[1] !== 0)
            $display("FAIL short_iorq_idle: busy=%b bracket=%0d, required 00/0", busy_o, n_bad[1]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        int w;
        clear_stats();
        bus_start(1'b1, 16'h81AB, 8'h5A, 1'b0);
        w = 0;
        while (stb_o[0] !== 1'b0 && w < 10) begin
            tick();
            w++;
        end
        n_checks++;
        if (stb_o[0] !== 1'b0) $display("FAIL rst_mid_reach_stb: wrstb_n=%b, required 0", stb_o[0]);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (stb_o !== 2'b11 || ena_o !== 2'b00 || busy_o !== 2'b00 || oe_o !== 2'b00)
            $display("FAIL rst_mid_outputs: wrstb_n=%b wrena=%b busy=%b oe=%b, required 11/00/00/00",
                     stb_o, ena_o, busy_o, oe_o);
        else n_pass++;
        bus_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_stats();
        repeat (12) tick();
        n_checks++;
        if (n_fall[0] !== 0 || n_fall[1] !== 0 || busy_o !== 2'b00)
            $display("FAIL rst_mid_no_pulse: pulses %0d/%0d busy=%b, required 0/0/00", n_fall[0], n_fall[1], busy_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [9:0] obs;
        logic [7:0] d1, d2;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        clear_stats();
        exp_q.delete();
        exp_q.push_back({2'b01, d1});
        exp_q.push_back({2'b10, d2});
        bus_start(1'b1, 16'h81AB, d1, 1'b0);
        repeat (12) tick();
        bus_idle();
        tick();
        access(1'b1, 16'h82AB, d2, 1'b0, 12);
        n_checks++;
        if (n_fall[0] !== 2 || n_fall[1] !== 2)
            $display("FAIL b2b_pulse_count: got %0d/%0d, required 2/2", n_fall[0], n_fall[1]);
        else n_pass++;
        while (exp_q.size() > 0) begin
            obs = (rise_q0.size() > 0) ? rise_q0.pop_front() : 10'bx;
            n_checks++;
            if (obs !== exp_q[0]) $display("FAIL b2b_data: got %h, required %h", obs, exp_q[0]);
            else n_pass++;
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_random();
        bit          is_wr, m1, exp_hit;
        logic [15:0] a;
        logic [7:0]  d;
        logic [9:0]  obs0, obs1;
        exp_q.delete();
        for (int n = 0; n < 24; n++) begin
            is_wr = 1'($urandom_range(0, 1));
            a = pick_addr();
            d = 8'($urandom);
            m1 = ($urandom_range(0, 5) == 0);
            exp_hit = model_hit(a, m1);
            if (exp_hit && is_wr) exp_q.push_back({model_port(a), d});
            clear_stats();
            access(is_wr, a, d, m1, $urandom_range(12, 30));
            n_checks++;
            if (n_fall[0] !== int'(exp_hit && is_wr) || n_fall[1] !== int'(exp_hit && is_wr))
                $display("FAIL rand_strobe a=%h wr=%0d m1=%0d: got %0d/%0d, required %0d",
                         a, is_wr, m1, n_fall[0], n_fall[1], int'(exp_hit && is_wr));
            else n_pass++;
            n_checks++;
            if (n_oe_rise[0] !== int'(exp_hit && !is_wr))
                $display("FAIL rand_oe a=%h wr=%0d m1=%0d: got %0d, required %0d",
                         a, is_wr, m1, n_oe_rise[0], int'(exp_hit && !is_wr));
            else n_pass++;
            if (exp_hit && is_wr) begin
                obs0 = (rise_q0.size() > 0) ? rise_q0.pop_front() : 10'bx;
                obs1 = (rise_q1.size() > 0) ? rise_q1.pop_front() : 10'bx;
                n_checks++;
                if (obs0 !== exp_q[0] || obs1 !== exp_q[0])
                    $display("FAIL rand_wr_data a=%h: got %h/%h, required %h", a, obs0, obs1, exp_q[0]);
                else n_pass++;
                void'(exp_q.pop_front());
                n_checks++;
                if (low_len[0] !== 2 || low_len[1] !== 4 || n_bad[0] !== 0 || n_bad[1] !== 0)
                    $display("FAIL rand_wr_shape: len %0d/%0d bracket %0d/%0d, required 2/4 0/0",
                             low_len[0], low_len[1], n_bad[0], n_bad[1]);
                else n_pass++;
            end
            if (exp_hit && !is_wr) begin
                n_checks++;
                if (oe_rise_cyc[0] - drive_cyc < OE_MIN || oe_rise_cyc[0] - drive_cyc > OE_MAX ||
                    oe_fall_cyc[0] - release_cyc < OE_MIN || oe_fall_cyc[0] - release_cyc > OE_MAX)
                    $display("FAIL rand_rd_timing a=%h: rise %0d fall %0d, required %0d..%0d",
                             a, oe_rise_cyc[0] - drive_cyc, oe_fall_cyc[0] - release_cyc, OE_MIN, OE_MAX);
                else n_pass++;
                n_checks++;
                if (addr_o[0] !== model_port(a))
                    $display("FAIL rand_rd_addr a=%h: got %b, required %b", a, addr_o[0], model_port(a));
                else n_pass++;
            end
        end
    endtask

`ifdef ZXPORTS_RDOE_ASYNC_EN
    task automatic test_async_oe();
        bus_start(1'b0, 16'h81AB, 8'h00, 1'b0);
        #1;
        n_checks++;
        if (oe_o !== 2'b11) $display("FAIL async_oe_on: got %b, required 11", oe_o);
        else n_pass++;
        repeat (5) tick();
        bus_idle();
        #1;
        n_checks++;
        if (oe_o !== 2'b00) $display("FAIL async_oe_off: got %b, required 00", oe_o);
        else n_pass++;
        repeat (8) tick();
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write();
        test_read();
        test_no_match();
        test_short_iorq();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
`ifdef ZXPORTS_RDOE_ASYNC_EN
        test_async_oe();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/zxbus_port_ctrl.md
# zxbus_port_ctrl

Bus-side access sequencer for the card's three I/O ports, #81AB, #82AB and #83AB. It synchronises the raw ZX bus I/O cycle to `clk` and decodes the port address. It then produces the port block's write interface (`wrstb_n`, `wrena`, `addr`, `wrdata`) and the data-bus output enable for reads. It sits directly upstream of the port register file. Read data itself stays combinational in the port block and is gated onto the bus by `zx_d_oe`.

## Interface
- `STB_LEN`, default 2: low time of `port_wrstb_n` in `clk` cycles. Legal range 1..15.
- `clk`  in  1  system clock. Must be at least 8× the Z80 clock.
- `rst`  in  1  asynchronous reset, active-high.
- `zx_a`  in  16  Z80 address bus.
- `zx_d`  in  8  Z80 data bus, input side.
- `zx_iorq_n`, `zx_rd_n`, `zx_wr_n`, `zx_m1_n`  in  1 each  raw Z80 strobes, active-low, asynchronous to `clk`.
- `port_addr`  out  2  port select: 2'b01 = #81AB, 2'b10 = #82AB, 2'b11 = #83AB.
- `port_wrdata`  out  8  captured write data.
- `port_wrena`  out  1  write enable to the port block.
- `port_wrstb_n`  out  1  write strobe, active-low. The port block latches on its rising edge.
- `zx_d_oe`  out  1  drive the port's read data onto the ZX data bus.
- `busy`  out  1  FSM not in IDLE (debug/status).

## Operation
- Synchronisation:
  - `zx_iorq_n`, `zx_rd_n`, `zx_wr_n` and `zx_m1_n` each pass through a 2-flop synchroniser, giving `iorq_s`, `rd_s`, `wr_s` and `m1_s`, all active-high internally.
- Decode (`hit`) is true only when all of the following hold:
  - `zx_a[7:0]` = 8'hAB,
  - `zx_a[15:10]` = 6'b100000,
  - `zx_a[9:8]` != 2'b00,
  - `iorq_s` = 1 and `m1_s` = 0.
  - Address and data are sampled on the cycle the FSM leaves IDLE. They are stable on the bus by then.
- FSM states: IDLE, WR_SETUP, WR_STB, WR_HOLD, RD_ACT, WAIT_END.
- Transitions out of IDLE:
  - IDLE → WR_SETUP when `hit` and `wr_s`. On this edge: `port_addr` ← `zx_a[9:8]`, `port_wrdata` ← `zx_d`, `port_wrena` ← 1.
  - IDLE → RD_ACT when `hit` and `rd_s`, with `port_addr` ← `zx_a[9:8]`.
  - If `wr_s` and `rd_s` are both set, write takes priority.
- Write sequence:
  - WR_SETUP → WR_STB after 1 cycle; `port_wrstb_n` ← 0.
  - WR_STB lasts exactly `STB_LEN` cycles, counted by a 4-bit counter. Then go to WR_HOLD with `port_wrstb_n` ← 1.
  - WR_HOLD lasts 1 cycle with `port_wrena` still 1. It then goes to WAIT_END with `port_wrena` ← 0.
- Read sequence:
  - RD_ACT: `zx_d_oe` = 1 (registered).
  - Leave RD_ACT for IDLE as soon as `rd_s` = 0 or `iorq_s` = 0; `zx_d_oe` ← 0 on that edge.
- WAIT_END → IDLE only when `iorq_s` = 0 and `wr_s` = 0. A held or stretched write therefore yields exactly one strobe.
- Abort rules:
  - IORQ released during WR_SETUP or WR_STB does not abort. The strobe always completes its full length, so the port block never sees a truncated pulse.
  - An M1 + IORQ cycle (interrupt acknowledge) never matches `hit`.
- Reset values: `port_addr` = 2'b00, `port_wrdata` = 8'h00, `port_wrena` = 0, `port_wrstb_n` = 1, `zx_d_oe` = 0, `busy` = 0, FSM = IDLE, counter = 0.
- Reset mid-operation forces every output to its reset value immediately, with no strobe edge generated by the FSM. The port block's own reset covers register state.

## Timing
- Write:
  - Raw `zx_wr_n` fall to WR_SETUP entry: 2–3 `clk` edges.
  - `port_wrstb_n` low from edge E+1 to edge E+1+`STB_LEN`, where E is the WR_SETUP entry edge.
  - `port_wrena` high from edge E to edge E+2+`STB_LEN`. It therefore brackets the rising strobe edge by at least 1 cycle on each side.
  - `port_addr` and `port_wrdata` hold steady from E until the next access.
- Read:
  - `zx_d_oe` asserts 3 edges after the raw `zx_rd_n` fall, give or take 1.
  - It deasserts 3 edges after the raw `zx_rd_n` or `zx_iorq_n` rise, give or take 1.
- Back-to-back accesses: a new access is accepted only from IDLE, at the earliest 1 cycle after WAIT_END or RD_ACT exit.

## Configuration
- `ZXPORTS_RDOE_ASYNC_EN`:
  - Defined: `zx_d_oe` is combinational from the raw bus, equal to `~zx_iorq_n & ~zx_rd_n & zx_m1_n & raw-address decode`. This gives zero-latency bus drive for slow `clk`. The RD_ACT state still runs but only drives `busy`.
  - Undefined: registered `zx_d_oe` as described above.

## Test plan
- Write: #83AB, data 8'h3C, `zx_wr_n` low for 40 cycles → exactly one `port_wrstb_n` low pulse of 2 cycles, with `port_addr` = 2'b11, `port_wrdata` = 8'h3C and `port_wrena` = 1 across the rising edge.
- Read: #82AB, `zx_rd_n` low for 20 cycles → `zx_d_oe` rises 2–4 cycles after the fall and falls 2–4 cycles after release; `port_addr` = 2'b10; no strobe.
- No match: accesses to #80AB, #83AA, #87AB, and M1 + IORQ with A = 16'h83AB → `zx_d_oe` stays 0 and `port_wrstb_n` stays 1.
- Short IORQ: IORQ released 1 cycle after WR_SETUP entry, with `STB_LEN` = 4 → full 4-cycle strobe, then IDLE.
- Reset mid-write: assert `rst` during WR_STB → `port_wrstb_n` = 1, `port_wrena` = 0, `busy` = 0 the same cycle; no further pulse after release.
- With `ZXPORTS_RDOE_ASYNC_EN` defined: read #81AB → `zx_d_oe` follows the raw `zx_rd_n` combinationally with 0 cycles of latency.
